// File: rtl/sig_mult_sched_if.sv
// Bundle of the two-lane request ports and the single result port of sig_mult_sched.
// The lane-packed vectors keep lane i at [i*W +: W].
interface sig_mult_sched_if #(
    parameter int SIG_WIDTH = 23,
    parameter int TAG_WIDTH = 4
);
    localparam int OP_W   = SIG_WIDTH + 1;
    localparam int PROD_W = 2 * SIG_WIDTH + 4;

    logic [1:0]             req_valid;
    logic [1:0]             req_ready;
    logic [2*OP_W-1:0]      req_a;
    logic [2*OP_W-1:0]      req_b;
    logic [2*TAG_WIDTH-1:0] req_tag;
    logic                   out_valid;
    logic                   out_ready;
    logic [PROD_W-1:0]      out_sum;
    logic [PROD_W-1:0]      out_carry;
    logic                   out_id;
    logic [TAG_WIDTH-1:0]   out_tag;
    logic [2:0]             inflight;

    modport master (
        output req_valid, req_a, req_b, req_tag, out_ready,
        input  req_ready, out_valid, out_sum, out_carry, out_id, out_tag, inflight
    );

    modport slave (
        input  req_valid, req_a, req_b, req_tag, out_ready,
        output req_ready, out_valid, out_sum, out_carry, out_id, out_tag, inflight
    );
endinterface

// File: rtl/sig_mult_sched.sv
// One significand multiplier shared round-robin by two FMA lanes, with a
// PIPE_STAGES-deep freeze-on-stall pipeline delivering redundant sum/carry.
module sig_mult_sched #(
    parameter int SIG_WIDTH   = 23,
    parameter int PIPE_STAGES = 2,
    parameter int TAG_WIDTH   = 4
) (
    input logic              clk,
    input logic              rst_n,
    sig_mult_sched_if.slave  bus
);
    localparam int OP_W   = SIG_WIDTH + 1;
    localparam int PROD_W = 2 * SIG_WIDTH + 4;
    localparam int LAST   = PIPE_STAGES - 1;

    logic [PIPE_STAGES-1:0] stage_valid;
    logic [PIPE_STAGES-1:0] stage_valid_next;
    logic                   rr_ptr;
    logic [2:0]             inflight_q;
    logic [2:0]             inflight_next;
    logic                   stall;
    logic [1:0]             grant;
    logic                   xfer;
    logic                   grant_id;

    // Stage 0: operands of the accepted request
    logic [OP_W-1:0]      a0;
    logic [OP_W-1:0]      b0;
    logic [TAG_WIDTH-1:0] tag0;
    logic                 id0;

    // Stages 1..LAST: redundant product with its id/tag
    logic [PROD_W-1:0]    sum_q   [1:LAST];
    logic [PROD_W-1:0]    carry_q [1:LAST];
    logic [TAG_WIDTH-1:0] tag_q   [1:LAST];
    logic                 id_q    [1:LAST];

    logic [PROD_W-1:0] mul_sum;
    logic [PROD_W-1:0] mul_carry;

    assign stall = stage_valid[LAST] & ~bus.out_ready;

    // Round-robin: the lane at the pointer wins, the other lane only if it is idle.
    // Gating with rst_n keeps req_ready low for the whole reset window.
    always_comb begin
        grant = '0;
        if (rst_n && !stall) begin
            if (rr_ptr == 1'b0) begin
                if (bus.req_valid[0])      grant = 2'b01;
                else if (bus.req_valid[1]) grant = 2'b10;
            end else begin
                if (bus.req_valid[1])      grant = 2'b10;
                else if (bus.req_valid[0]) grant = 2'b01;
            end
        end
    end

    assign xfer          = |grant;
    assign grant_id      = grant[1];
    assign bus.req_ready = grant;

    always_comb begin
        stage_valid_next = stage_valid;
        if (!stall) stage_valid_next = {stage_valid[PIPE_STAGES-2:0], xfer};
        inflight_next = '0;
        for (int k = 0; k < PIPE_STAGES; k++)
            inflight_next = inflight_next + {2'b00, stage_valid_next[k]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_valid <= '0;
            rr_ptr      <= 1'b0;
            inflight_q  <= '0;
        end else begin
            stage_valid <= stage_valid_next;
            inflight_q  <= inflight_next;
            if (xfer) rr_ptr <= ~grant_id;
        end
    end

    // NOTE: datapath registers carry no reset; only the valid bits qualify them,
    // so resetting wide data would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (xfer) begin
            a0   <= grant_id ? bus.req_a[2*OP_W-1:OP_W] : bus.req_a[OP_W-1:0];
            b0   <= grant_id ? bus.req_b[2*OP_W-1:OP_W] : bus.req_b[OP_W-1:0];
            tag0 <= grant_id ? bus.req_tag[2*TAG_WIDTH-1:TAG_WIDTH] : bus.req_tag[TAG_WIDTH-1:0];
            id0  <= grant_id;
        end
        if (!stall) begin
            sum_q[1]   <= mul_sum;
            carry_q[1] <= mul_carry;
            tag_q[1]   <= tag0;
            id_q[1]    <= id0;
            for (int k = 2; k <= LAST; k++) begin
                sum_q[k]   <= sum_q[k-1];
                carry_q[k] <= carry_q[k-1];
                tag_q[k]   <= tag_q[k-1];
                id_q[k]    <= id_q[k-1];
            end
        end
    end

    // Carry-save accumulation of the partial products: each step is a row of
    // full adders, so sum + 2*carry always equals the running product.
    always_comb begin
        logic [PROD_W-1:0] pp;
        logic [PROD_W-1:0] c_sh;
        logic [PROD_W-1:0] nxt_s;
        mul_sum   = '0;
        mul_carry = '0;
        pp        = '0;
        c_sh      = '0;
        nxt_s     = '0;
        // NOTE: blocking assignments here are deliberate; each iteration reads
        // the value produced by the previous one within the same evaluation.
        for (int i = 0; i < OP_W; i++) begin
            pp        = b0[i] ? (PROD_W'(a0) << i) : '0;
            c_sh      = {mul_carry[PROD_W-2:0], 1'b0};
            nxt_s     = mul_sum ^ c_sh ^ pp;
            mul_carry = (mul_sum & c_sh) | (mul_sum & pp) | (c_sh & pp);
            mul_sum   = nxt_s;
        end
    end

    assign bus.out_valid = stage_valid[LAST];
    assign bus.out_sum   = sum_q[LAST];
    assign bus.out_carry = carry_q[LAST];
    assign bus.out_tag   = tag_q[LAST];
    assign bus.out_id    = id_q[LAST];
    assign bus.inflight  = inflight_q;
endmodule

// File: tb/tb_sig_mult_sched.sv
// Directed and random stimulus for sig_mult_sched against a transaction-level
// model: a queue of accepted requests, each aging one step per unstalled cycle.
module tb_sig_mult_sched;
    localparam int SW   = 23;
    localparam int PS   = 2;
    localparam int TW   = 4;
    localparam int OP_W = SW + 1;
    localparam int PW   = 2 * SW + 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sig_mult_sched_if #(.SIG_WIDTH(SW), .TAG_WIDTH(TW)) bus ();

    sig_mult_sched #(.SIG_WIDTH(SW), .PIPE_STAGES(PS), .TAG_WIDTH(TW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] dut_prod();
        logic [PW-1:0] p;
        p = bus.out_sum + {bus.out_carry[PW-2:0], 1'b0};
        return {14'b0, p};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [OP_W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return 24'hFFFFFF;
            2:       return 24'h800000;
            default: return OP_W'($urandom);
        endcase
    endfunction

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
        logic [TW-1:0]   tag;
        logic            id;
        int              age;
    } item_t;

    item_t q[$];
    logic  ptr_m = 1'b0;

    // Checks the current cycle, then advances the model to the state after the next edge.
    always @(negedge clk) begin : model_chk
        logic       exp_ov;
        logic       stall_m;
        logic [1:0] exp_rdy;
        item_t      it;
        if (!rst_n) begin
            q.delete();
            ptr_m = 1'b0;
            check("rst_out_valid", 64'(bus.out_valid), 64'(0));
            check("rst_inflight", 64'(bus.inflight), 64'(0));
            check("rst_req_ready", 64'(bus.req_ready), 64'(0));
        end else begin
            exp_ov  = (q.size() > 0) && (q[0].age == PS - 1);
            stall_m = exp_ov && !bus.out_ready;
            check("out_valid", 64'(bus.out_valid), 64'(exp_ov));
            check("inflight", 64'(bus.inflight), 64'(q.size()));
            exp_rdy = 2'b00;
            if (!stall_m) begin
                if (bus.req_valid[ptr_m])       exp_rdy[ptr_m]  = 1'b1;
                else if (bus.req_valid[~ptr_m]) exp_rdy[~ptr_m] = 1'b1;
            end
            check("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
            if (exp_ov && bus.out_valid) begin
                check("product", dut_prod(), 64'(q[0].a) * 64'(q[0].b));
                check("out_id", 64'(bus.out_id), 64'(q[0].id));
                check("out_tag", 64'(bus.out_tag), 64'(q[0].tag));
            end
            if (!stall_m) begin
                if (exp_ov && bus.out_ready) void'(q.pop_front());
                foreach (q[i]) q[i].age++;
                if (exp_rdy != 2'b00) begin
                    it.id  = exp_rdy[1];
                    it.a   = it.id ? bus.req_a[2*OP_W-1:OP_W] : bus.req_a[OP_W-1:0];
                    it.b   = it.id ? bus.req_b[2*OP_W-1:OP_W] : bus.req_b[OP_W-1:0];
                    it.tag = it.id ? bus.req_tag[2*TW-1:TW] : bus.req_tag[TW-1:0];
                    it.age = 0;
                    q.push_back(it);
                    ptr_m = ~it.id;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [PW-1:0] snap_sum;
    logic [PW-1:0] snap_carry;
    logic [TW-1:0] snap_tag;

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic drive_lane(input int lane, input logic [OP_W-1:0] a,
                              input logic [OP_W-1:0] b, input logic [TW-1:0] tag);
        if (lane == 0) begin
            bus.req_a[OP_W-1:0] = a;
            bus.req_b[OP_W-1:0] = b;
            bus.req_tag[TW-1:0] = tag;
        end else begin
            bus.req_a[2*OP_W-1:OP_W] = a;
            bus.req_b[2*OP_W-1:OP_W] = b;
            bus.req_tag[2*TW-1:TW]   = tag;
        end
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_tag   = '0;
        bus.out_ready = 1'b1;
        do_reset();
        check("reset_inflight", 64'(bus.inflight), 64'(0));
        check("reset_out_valid", 64'(bus.out_valid), 64'(0));

        // 1: single lane-0 request, 2^23 * 2^23 = 2^46
        drive_lane(0, 24'h800000, 24'h800000, 4'hA);
        bus.req_valid = 2'b01;
        #1 check("t1_grant", 64'(bus.req_ready), 64'(2'b01));
        step();
        bus.req_valid = 2'b00;
        check("t1_lat1_valid", 64'(bus.out_valid), 64'(0));
        check("t1_lat1_inflight", 64'(bus.inflight), 64'(1));
        step();
        check("t1_lat2_valid", 64'(bus.out_valid), 64'(1));
        check("t1_product", dut_prod(), 64'h0000_4000_0000_0000);
        check("t1_id", 64'(bus.out_id), 64'(0));
        check("t1_tag", 64'(bus.out_tag), 64'hA);
        step();
        check("t1_done_valid", 64'(bus.out_valid), 64'(0));
        check("t1_done_inflight", 64'(bus.inflight), 64'(0));

        // 2: both lanes valid for 8 cycles, grants alternate from lane 0
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive_lane(0, OP_W'(1000 + i), OP_W'(3 + i), TW'(i));
            drive_lane(1, OP_W'(77 * (i + 1)), 24'hFFFFFF, TW'(15 - i));
            bus.req_valid = 2'b11;
            #1 check("t2_alternate", 64'(bus.req_ready), (i % 2 == 0) ? 64'(2'b01) : 64'(2'b10));
            step();
        end
        bus.req_valid = 2'b00;
        for (int i = 0; i < PS + 1; i++) step();

        // 3: lane-1 stream with a 3-cycle output stall mid-stream
        for (int i = 0; i < 3; i++) begin
            drive_lane(1, OP_W'(5000 + i), OP_W'(i), TW'(i + 1));
            bus.req_valid = 2'b10;
            step();
        end
        bus.out_ready = 1'b0;
        #1;
        snap_sum   = bus.out_sum;
        snap_carry = bus.out_carry;
        snap_tag   = bus.out_tag;
        for (int i = 0; i < 3; i++) begin
            drive_lane(1, OP_W'(6000 + i), 24'h800000, TW'(i + 8));
            #1;
            check("t3_stall_ready", 64'(bus.req_ready), 64'(0));
            check("t3_stall_inflight", 64'(bus.inflight), 64'(PS));
            check("t3_frozen_sum", 64'(bus.out_sum), 64'(snap_sum));
            check("t3_frozen_carry", 64'(bus.out_carry), 64'(snap_carry));
            check("t3_frozen_tag", 64'(bus.out_tag), 64'(snap_tag));
            step();
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        bus.req_valid = 2'b00;
        for (int i = 0; i < PS + 1; i++) step();

        // 4: asynchronous reset with two results in flight
        drive_lane(0, 24'h123456, 24'h654321, 4'h3);
        bus.req_valid = 2'b01;
        step();
        step();
        check("t4_pre_inflight", 64'(bus.inflight), 64'(2));
        #2 rst_n = 1'b0;
        #1;
        check("t4_rst_valid", 64'(bus.out_valid), 64'(0));
        check("t4_rst_inflight", 64'(bus.inflight), 64'(0));
        step();
        bus.req_valid = 2'b11;
        drive_lane(1, 24'h000002, 24'h000003, 4'h7);
        step();
        rst_n = 1'b1;
        #1 check("t4_ptr_lane0", 64'(bus.req_ready), 64'(2'b01));
        bus.req_valid = 2'b00;
        step();
        check("t4_no_stale", 64'(bus.out_valid), 64'(0));
        for (int i = 0; i < PS + 1; i++) step();

        // 5: random traffic and backpressure, model checks every cycle
        for (int i = 0; i < 12000; i++) begin
            drive_lane(0, pick(), pick(), TW'($urandom));
            drive_lane(1, pick(), pick(), TW'($urandom));
            bus.req_valid = 2'($urandom_range(0, 3));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        bus.req_valid = 2'b00;
        bus.out_ready = 1'b1;
        for (int i = 0; i < PS + 3; i++) step();
        check("drain_inflight", 64'(bus.inflight), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
